n_clic_stack: RTL

Hardware nesting stack for the n_clic interrupt path. When n_clic takes an interrupt, the core pushes the interrupted return PC and the current priority threshold. When the ISR returns (jalr to the return sentinel), the core pops the stack to restore both values. The stack sits beside n_clic in top_n_clic and supplies the nesting level used to select the register-file bank (rf.regs[level]).

---
 rtl/config_pkg.sv | 23 ++
 rtl/n_clic_stack.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/config_pkg.sv
// Shared configuration for the n_clic interrupt path: widths, nesting depth,
// the ISR return sentinel and the saved-context entry layout.
package config_pkg;

  localparam int PrioWidth = 3;
  localparam int NestDepth = 8;
  localparam int PcWidth   = 32;

  // jalr target that the decoder recognises as "return from ISR" (raises pop)
  localparam logic [PcWidth-1:0] RetSentinel = 32'hFFFF_FFFE;

  // One saved context: interrupted return PC and the threshold to restore
  typedef struct packed {
    logic [PcWidth-1:0]   pc;
    logic [PrioWidth-1:0] prev_thresh;
  } stack_entry_t;

  // Width of a counter able to hold 0..depth inclusive
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/n_clic_stack.sv
// Interrupt nesting stack: saves {return PC, previous threshold} on interrupt
// entry, restores the threshold on ISR return, and reports the nesting level
// used to select the register-file bank.
module n_clic_stack
  import config_pkg::*;
#(
  parameter int PrioWidth = config_pkg::PrioWidth,
  parameter int Depth     = NestDepth,
  parameter int PcWidth   = config_pkg::PcWidth
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [PcWidth-1:0]                 push_pc,
  input  logic [PrioWidth-1:0]               push_prio,
  input  logic                               pop,
  output logic [PcWidth-1:0]                 ret_pc,
  output logic [PrioWidth-1:0]               thresh_out,
  output logic [level_width(Depth)-1:0]      level_out,
  output logic                               full,
  output logic                               empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int LevelWidth = level_width(Depth);
  localparam int IdxWidth   = (Depth > 1) ? $clog2(Depth) : 1;

  // Entry layout sized by this instance's parameters
  typedef struct packed {
    logic [PcWidth-1:0]   pc;
    logic [PrioWidth-1:0] prev_thresh;
  } entry_t;

  entry_t                  entry_r [Depth];
  logic [LevelWidth-1:0]   level_r;
  logic [PrioWidth-1:0]    thresh_r;
  logic                    overflow_r;
  logic                    underflow_r;

  logic [LevelWidth-1:0]   level_nxt_s;
  logic [PrioWidth-1:0]    thresh_nxt_s;
  logic                    wr_en_s;
  logic                    ovf_set_s;
  logic                    unf_set_s;
  logic [IdxWidth-1:0]     wr_idx_s;
  logic [IdxWidth-1:0]     top_idx_s;
  logic                    full_s;
  logic                    empty_s;

  assign full_s    = (level_r == LevelWidth'(Depth));
  assign empty_s   = (level_r == {LevelWidth{1'b0}});
  assign wr_idx_s  = IdxWidth'(level_r);
  assign top_idx_s = IdxWidth'(level_r - LevelWidth'(1));

  // Next-state decode for push, pop, tail-chain and the full/empty guards
  always_comb begin
    level_nxt_s  = level_r;
    thresh_nxt_s = thresh_r;
    wr_en_s      = 1'b0;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          wr_en_s      = 1'b1;
          thresh_nxt_s = push_prio;
          level_nxt_s  = level_r + LevelWidth'(1);
        end
      end
      2'b01: begin
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else begin
          thresh_nxt_s = entry_r[top_idx_s].prev_thresh;
          level_nxt_s  = level_r - LevelWidth'(1);
        end
      end
      2'b11: begin
        // Tail-chain keeps the saved context; from empty it is a plain push
        if (empty_s) begin
          wr_en_s      = 1'b1;
          thresh_nxt_s = push_prio;
          level_nxt_s  = level_r + LevelWidth'(1);
        end else begin
          thresh_nxt_s = push_prio;
        end
      end
      default: begin
        level_nxt_s  = level_r;
        thresh_nxt_s = thresh_r;
      end
    endcase
  end

  // Level, threshold and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r     <= {LevelWidth{1'b0}};
      thresh_r    <= {PrioWidth{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      level_r     <= level_nxt_s;
      thresh_r    <= thresh_nxt_s;
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
    end
  end

  // Saved-context storage; reset clears every entry so stale PCs never leak
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        entry_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      entry_r[wr_idx_s] <= '{pc: push_pc, prev_thresh: thresh_r};
    end
  end

  // Top-of-stack PC, available in the same cycle the core asserts pop
  always_comb begin
    if (empty_s) begin
      ret_pc = {PcWidth{1'b0}};
    end else begin
      ret_pc = entry_r[top_idx_s].pc;
    end
  end

  assign thresh_out = thresh_r;
  assign level_out  = level_r;
  assign full       = full_s;
  assign empty      = empty_s;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;

endmodule
